// File: rtl/ddr_amm_arbiter_if.sv
// ddr_amm_arbiter_if: one Avalon-MM link (requester side or DDR side).
// master drives the command, slave answers with ready and read data.
interface ddr_amm_arbiter_if #(
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 256,
  parameter int BE_W    = 32,
  parameter int BURST_W = 7
) ();
  logic [ADDR_W-1:0]  addr;
  logic               read;
  logic               write;
  logic [DATA_W-1:0]  writedata;
  logic [BE_W-1:0]    byteenable;
  logic [BURST_W-1:0] burstcount;
  logic               ready;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;

  modport master (
    output addr, read, write,
    output writedata, byteenable, burstcount,
    input  ready, readdata, readdatavalid
  );

  modport slave (
    input  addr, read, write,
    input  writedata, byteenable, burstcount,
    output ready, readdata, readdatavalid
  );
endinterface

// File: rtl/ddr_amm_arbiter.sv
// ddr_amm_arbiter: round-robin two-port arbiter for the DDR Avalon-MM master.
// Define DDR_ARB_TIMEOUT_EN to add the read-data watchdog and rd_timeout.
module ddr_amm_arbiter #(
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 256,
  parameter int BE_W    = 32,
  parameter int BURST_W = 7
`ifdef DDR_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic              avalon_clk,
  input  logic              avalon_reset,
  ddr_amm_arbiter_if.slave  m0,
  ddr_amm_arbiter_if.slave  m1,
  ddr_amm_arbiter_if.master amm,
  output logic [1:0]        grant,
  output logic              stray_rdv
`ifdef DDR_ARB_TIMEOUT_EN
  ,
  output logic              rd_timeout
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_CMD,
    RD_DATA
  } state_t;

  state_t state, state_d;

  logic               own, own_d;
  logic               last_owner, last_d;
  logic [1:0]         grant_d;
  logic               wr_started;
  logic [BURST_W-1:0] beats_left;
  logic [BURST_W-1:0] bc_lat;
  logic [BURST_W-1:0] rd_left;
  logic [BURST_W-1:0] first_bl;
  logic               req0, req1;
  logic               wr_acc, rd_acc;

  logic [ADDR_W-1:0]  s_addr;
  logic               s_read, s_write;
  logic [DATA_W-1:0]  s_wdata;
  logic [BE_W-1:0]    s_be;
  logic [BURST_W-1:0] s_bc;

`ifdef DDR_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            to_d;
`endif

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  assign m0.readdata = amm.readdata;
  assign m1.readdata = amm.readdata;

  always_comb begin
    s_addr  = own ? m1.addr       : m0.addr;
    s_read  = own ? m1.read       : m0.read;
    s_write = own ? m1.write      : m0.write;
    s_wdata = own ? m1.writedata  : m0.writedata;
    s_be    = own ? m1.byteenable : m0.byteenable;
    s_bc    = own ? m1.burstcount : m0.burstcount;
  end

  // A zero burstcount behaves as a single beat
  assign first_bl = (s_bc == '0) ? '0 : s_bc - BURST_W'(1);

  always_comb begin
    state_d          = state;
    own_d            = own;
    last_d           = last_owner;
    grant_d          = grant;
    amm.addr         = '0;
    amm.writedata    = '0;
    amm.byteenable   = '0;
    amm.burstcount   = '0;
    amm.read         = 1'b0;
    amm.write        = 1'b0;
    m0.ready         = 1'b0;
    m1.ready         = 1'b0;
    m0.readdatavalid = 1'b0;
    m1.readdatavalid = 1'b0;
    wr_acc           = 1'b0;
    rd_acc           = 1'b0;
`ifdef DDR_ARB_TIMEOUT_EN
    to_d             = 1'b0;
`endif
    if (!avalon_reset) begin
      if (state == WR_BURST || state == RD_CMD) begin
        amm.addr       = s_addr;
        amm.writedata  = s_wdata;
        amm.byteenable = s_be;
        amm.burstcount = s_bc;
        m0.ready       = ~own & amm.ready;
        m1.ready       = own & amm.ready;
      end
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            own_d   = (req0 & req1) ? ~last_owner : req1;
            last_d  = own_d;
            grant_d = own_d ? 2'b10 : 2'b01;
            state_d = (own_d ? m1.write : m0.write) ? WR_BURST : RD_CMD;
          end
        end
        WR_BURST: begin
          if (wr_started) amm.burstcount = bc_lat;
          amm.write = s_write;
          wr_acc    = s_write & amm.ready;
          if (wr_acc) begin
            if (wr_started ? (beats_left == BURST_W'(1)) : (first_bl == '0)) begin
              state_d = IDLE;
              grant_d = 2'b00;
            end
          end
        end
        RD_CMD: begin
          amm.read = s_read;
          rd_acc   = s_read & amm.ready;
          if (rd_acc) state_d = RD_DATA;
        end
        RD_DATA: begin
          if (amm.readdatavalid) begin
            m0.readdatavalid = ~own;
            m1.readdatavalid = own;
            if (rd_left == BURST_W'(1)) begin
              state_d = IDLE;
              grant_d = 2'b00;
            end
          end
`ifdef DDR_ARB_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;
            grant_d = 2'b00;
            to_d    = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge avalon_clk) begin
    if (avalon_reset) begin
      state      <= IDLE;
      own        <= 1'b0;
      last_owner <= 1'b1;
      grant      <= 2'b00;
      wr_started <= 1'b0;
      beats_left <= '0;
      bc_lat     <= '0;
      rd_left    <= '0;
      stray_rdv  <= 1'b0;
    end else begin
      state      <= state_d;
      own        <= own_d;
      last_owner <= last_d;
      grant      <= grant_d;
      if (state != WR_BURST) begin
        wr_started <= 1'b0;
      end else if (wr_acc && !wr_started) begin
        wr_started <= 1'b1;
        beats_left <= first_bl;
        bc_lat     <= s_bc;
      end else if (wr_acc) begin
        beats_left <= beats_left - BURST_W'(1);
      end
      if (rd_acc) begin
        rd_left <= (s_bc == '0) ? BURST_W'(1) : s_bc;
      end else if (state == RD_DATA && amm.readdatavalid) begin
        rd_left <= rd_left - BURST_W'(1);
      end
      // Beats with no read outstanding are dropped but remembered
      if (amm.readdatavalid && state != RD_DATA) stray_rdv <= 1'b1;
    end
  end

`ifdef DDR_ARB_TIMEOUT_EN
  always_ff @(posedge avalon_clk) begin
    if (avalon_reset) begin
      wd_cnt     <= '0;
      rd_timeout <= 1'b0;
    end else begin
      rd_timeout <= to_d;
      if (state != RD_DATA || amm.readdatavalid) wd_cnt <= '0;
      else wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ddr_amm_arbiter.sv
// tb_ddr_amm_arbiter: directed scenarios for the two-port DDR arbiter.
// Expected values are hand-derived from the arbitration rules.
module tb_ddr_amm_arbiter;
  localparam int ADDR_W  = 25;
  localparam int DATA_W  = 256;
  localparam int BE_W    = 32;
  localparam int BURST_W = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant;
  logic       stray_rdv;
`ifdef DDR_ARB_TIMEOUT_EN
  logic       rd_timeout;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ddr_amm_arbiter_if #(ADDR_W, DATA_W, BE_W, BURST_W) m0_if ();
  ddr_amm_arbiter_if #(ADDR_W, DATA_W, BE_W, BURST_W) m1_if ();
  ddr_amm_arbiter_if #(ADDR_W, DATA_W, BE_W, BURST_W) amm_if ();

  always #5 clk = ~clk;

  ddr_amm_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .BE_W       (BE_W),
    .BURST_W    (BURST_W)
`ifdef DDR_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(16)
`endif
  ) dut (
    .avalon_clk  (clk),
    .avalon_reset(rst),
    .m0          (m0_if),
    .m1          (m1_if),
    .amm         (amm_if),
    .grant       (grant),
    .stray_rdv   (stray_rdv)
`ifdef DDR_ARB_TIMEOUT_EN
    ,
    .rd_timeout  (rd_timeout)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [DATA_W-1:0] beat_val(int i);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(i);
    return {8{w}};
  endfunction

  task automatic clear_inputs();
    m0_if.addr = '0; m0_if.read = 0; m0_if.write = 0;
    m0_if.writedata = '0; m0_if.byteenable = '0;
    m0_if.burstcount = '0;
    m1_if.addr = '0; m1_if.read = 0; m1_if.write = 0;
    m1_if.writedata = '0; m1_if.byteenable = '0;
    m1_if.burstcount = '0;
    amm_if.ready = 0; amm_if.readdata = '0;
    amm_if.readdatavalid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    m0_if.read = 1'b1;
    amm_if.ready = 1'b1;
    tick();
    tick();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant: got %b exp 00", grant); end
    n_checks++; if (stray_rdv !== 1'b0) begin n_fail++; $display("FAIL rst_stray: got %b exp 0", stray_rdv); end
    n_checks++; if (amm_if.read !== 1'b0) begin n_fail++; $display("FAIL rst_amm_read: got %b exp 0", amm_if.read); end
    n_checks++; if (amm_if.write !== 1'b0) begin n_fail++; $display("FAIL rst_amm_write: got %b exp 0", amm_if.write); end
    n_checks++; if (amm_if.addr !== '0) begin n_fail++; $display("FAIL rst_amm_addr: got %h exp 0", amm_if.addr); end
    n_checks++; if (m0_if.ready !== 1'b0) begin n_fail++; $display("FAIL rst_m0_ready: got %b exp 0", m0_if.ready); end
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_read_single();
    logic [DATA_W-1:0] d;
    d = beat_val(16);
    m0_if.addr = 25'h10;
    m0_if.burstcount = 7'd1;
    m0_if.read = 1'b1;
    amm_if.ready = 1'b1;
    settle();
    n_checks++; if (m0_if.ready !== 1'b0) begin n_fail++; $display("FAIL rd_idle_ready: got %b exp 0", m0_if.ready); end
    n_checks++; if (amm_if.read !== 1'b0) begin n_fail++; $display("FAIL rd_idle_amm_read: got %b exp 0", amm_if.read); end
    tick();
    settle();
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rd_grant: got %b exp 01", grant); end
    n_checks++; if (amm_if.read !== 1'b1) begin n_fail++; $display("FAIL rd_amm_read: got %b exp 1", amm_if.read); end
    n_checks++; if (amm_if.addr !== 25'h10) begin n_fail++; $display("FAIL rd_amm_addr: got %h exp 10", amm_if.addr); end
    n_checks++; if (m0_if.ready !== 1'b1) begin n_fail++; $display("FAIL rd_m0_ready: got %b exp 1", m0_if.ready); end
    n_checks++; if (m1_if.ready !== 1'b0) begin n_fail++; $display("FAIL rd_m1_ready: got %b exp 0", m1_if.ready); end
    tick();
    m0_if.read = 1'b0;
    settle();
    n_checks++; if (amm_if.read !== 1'b0) begin n_fail++; $display("FAIL rd_data_amm_read: got %b exp 0", amm_if.read); end
    tick();
    tick();
    amm_if.readdata = d;
    amm_if.readdatavalid = 1'b1;
    settle();
    n_checks++; if (m0_if.readdatavalid !== 1'b1) begin n_fail++; $display("FAIL rd_m0_rdv: got %b exp 1", m0_if.readdatavalid); end
    n_checks++; if (m1_if.readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rd_m1_rdv: got %b exp 0", m1_if.readdatavalid); end
    n_checks++; if (m0_if.readdata !== d) begin n_fail++; $display("FAIL rd_m0_data: got %h exp %h", m0_if.readdata[31:0], d[31:0]); end
    n_checks++; if (m1_if.readdata !== d) begin n_fail++; $display("FAIL rd_m1_data: got %h exp %h", m1_if.readdata[31:0], d[31:0]); end
    tick();
    amm_if.readdatavalid = 1'b0;
    settle();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rd_done_grant: got %b exp 00", grant); end
    n_checks++; if (stray_rdv !== 1'b0) begin n_fail++; $display("FAIL rd_stray: got %b exp 0", stray_rdv); end
  endtask

  task automatic test_write_burst();
    int beats;
    logic exp_rdy;
    m1_if.addr = 25'h200;
    m1_if.burstcount = 7'd4;
    m1_if.byteenable = '1;
    m1_if.writedata = beat_val(0);
    m1_if.write = 1'b1;
    amm_if.ready = 1'b0;
    tick();
    beats = 0;
    for (int k = 0; k < 16 && beats < 4; k++) begin
      exp_rdy = (k % 2 == 0);
      amm_if.ready = exp_rdy;
      settle();
      n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL wr_grant k=%0d: got %b exp 10", k, grant); end
      n_checks++; if (amm_if.write !== 1'b1) begin n_fail++; $display("FAIL wr_amm_write k=%0d: got %b exp 1", k, amm_if.write); end
      n_checks++; if (amm_if.burstcount !== 7'd4) begin n_fail++; $display("FAIL wr_bc k=%0d: got %0d exp 4", k, amm_if.burstcount); end
      n_checks++; if (m1_if.ready !== exp_rdy) begin n_fail++; $display("FAIL wr_m1_ready k=%0d: got %b exp %b", k, m1_if.ready, exp_rdy); end
      n_checks++; if (m0_if.ready !== 1'b0) begin n_fail++; $display("FAIL wr_m0_ready k=%0d: got %b exp 0", k, m0_if.ready); end
      if (amm_if.write && amm_if.ready) begin
        n_checks++; if (amm_if.writedata !== beat_val(beats)) begin n_fail++; $display("FAIL wr_data b=%0d: got %h", beats, amm_if.writedata[31:0]); end
        beats++;
      end
      tick();
      m1_if.writedata = beat_val(beats);
      m1_if.burstcount = 7'd0;
    end
    m1_if.write = 1'b0;
    amm_if.ready = 1'b0;
    settle();
    n_checks++; if (beats !== 4) begin n_fail++; $display("FAIL wr_beats: got %0d exp 4", beats); end
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL wr_done_grant: got %b exp 00", grant); end
    n_checks++; if (amm_if.write !== 1'b0) begin n_fail++; $display("FAIL wr_done_write: got %b exp 0", amm_if.write); end
  endtask

  task automatic test_both_read();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      m0_if.addr = 25'(32'h100 + r);
      m1_if.addr = 25'(32'h180 + r);
      m0_if.burstcount = 7'd1;
      m1_if.burstcount = 7'd1;
      m0_if.read = 1'b1;
      m1_if.read = 1'b1;
      amm_if.ready = 1'b1;
      tick();
      settle();
      n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL both_grant0 r=%0d: got %b exp 01", r, grant); end
      n_checks++; if (amm_if.addr !== m0_if.addr) begin n_fail++; $display("FAIL both_addr0 r=%0d: got %h exp %h", r, amm_if.addr, m0_if.addr); end
      n_checks++; if (m1_if.ready !== 1'b0) begin n_fail++; $display("FAIL both_m1_hold r=%0d: got %b exp 0", r, m1_if.ready); end
      tick();
      m0_if.read = 1'b0;
      amm_if.readdatavalid = 1'b1;
      settle();
      n_checks++; if ({m1_if.readdatavalid, m0_if.readdatavalid} !== 2'b01) begin n_fail++; $display("FAIL both_rdv0 r=%0d: got %b%b exp 01", r, m1_if.readdatavalid, m0_if.readdatavalid); end
      tick();
      amm_if.readdatavalid = 1'b0;
      settle();
      n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL both_idle0 r=%0d: got %b exp 00", r, grant); end
      tick();
      settle();
      n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL both_grant1 r=%0d: got %b exp 10", r, grant); end
      n_checks++; if (amm_if.addr !== m1_if.addr) begin n_fail++; $display("FAIL both_addr1 r=%0d: got %h exp %h", r, amm_if.addr, m1_if.addr); end
      n_checks++; if (m0_if.ready !== 1'b0) begin n_fail++; $display("FAIL both_m0_ready r=%0d: got %b exp 0", r, m0_if.ready); end
      tick();
      m1_if.read = 1'b0;
      amm_if.readdatavalid = 1'b1;
      settle();
      n_checks++; if ({m1_if.readdatavalid, m0_if.readdatavalid} !== 2'b10) begin n_fail++; $display("FAIL both_rdv1 r=%0d: got %b%b exp 10", r, m1_if.readdatavalid, m0_if.readdatavalid); end
      tick();
      amm_if.readdatavalid = 1'b0;
      settle();
      n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL both_idle1 r=%0d: got %b exp 00", r, grant); end
    end
  endtask

  task automatic test_hold();
    logic v;
    m0_if.addr = 25'h300;
    m0_if.burstcount = 7'd8;
    m0_if.read = 1'b1;
    m1_if.addr = 25'h400;
    m1_if.burstcount = 7'd1;
    m1_if.writedata = beat_val(9);
    m1_if.write = 1'b1;
    amm_if.ready = 1'b1;
    tick();
    settle();
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL hold_grant: got %b exp 01", grant); end
    tick();
    m0_if.read = 1'b0;
    for (int i = 0; i < 9; i++) begin
      v = (i != 3);
      amm_if.readdatavalid = v;
      settle();
      n_checks++; if (m1_if.ready !== 1'b0) begin n_fail++; $display("FAIL hold_m1_ready i=%0d: got %b exp 0", i, m1_if.ready); end
      n_checks++; if (m0_if.readdatavalid !== v) begin n_fail++; $display("FAIL hold_m0_rdv i=%0d: got %b exp %b", i, m0_if.readdatavalid, v); end
      n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL hold_grant i=%0d: got %b exp 01", i, grant); end
      tick();
    end
    amm_if.readdatavalid = 1'b0;
    settle();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL hold_idle: got %b exp 00", grant); end
    n_checks++; if (m1_if.ready !== 1'b0) begin n_fail++; $display("FAIL hold_idle_ready: got %b exp 0", m1_if.ready); end
    tick();
    settle();
    n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL hold_grant1: got %b exp 10", grant); end
    n_checks++; if (m1_if.ready !== 1'b1) begin n_fail++; $display("FAIL hold_m1_go: got %b exp 1", m1_if.ready); end
    n_checks++; if (amm_if.writedata !== beat_val(9)) begin n_fail++; $display("FAIL hold_wdata: got %h", amm_if.writedata[31:0]); end
    tick();
    m1_if.write = 1'b0;
    settle();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL hold_done: got %b exp 00", grant); end
  endtask

  task automatic test_stray();
    settle();
    n_checks++; if (stray_rdv !== 1'b0) begin n_fail++; $display("FAIL stray_pre: got %b exp 0", stray_rdv); end
    amm_if.readdatavalid = 1'b1;
    settle();
    n_checks++; if ({m1_if.readdatavalid, m0_if.readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL stray_rdv_out: got %b%b exp 00", m1_if.readdatavalid, m0_if.readdatavalid); end
    tick();
    amm_if.readdatavalid = 1'b0;
    settle();
    n_checks++; if (stray_rdv !== 1'b1) begin n_fail++; $display("FAIL stray_set: got %b exp 1", stray_rdv); end
    tick(); tick(); tick();
    n_checks++; if (stray_rdv !== 1'b1) begin n_fail++; $display("FAIL stray_sticky: got %b exp 1", stray_rdv); end
    do_reset();
    settle();
    n_checks++; if (stray_rdv !== 1'b0) begin n_fail++; $display("FAIL stray_clear: got %b exp 0", stray_rdv); end
  endtask

  task automatic test_reset_mid();
    m0_if.burstcount = 7'd2;
    m0_if.read = 1'b1;
    amm_if.ready = 1'b1;
    tick();
    tick();
    m0_if.read = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL mid_grant: got %b exp 00", grant); end
    amm_if.readdatavalid = 1'b1;
    settle();
    n_checks++; if (m0_if.readdatavalid !== 1'b0) begin n_fail++; $display("FAIL mid_rdv: got %b exp 0", m0_if.readdatavalid); end
    tick();
    amm_if.readdatavalid = 1'b0;
    settle();
    n_checks++; if (stray_rdv !== 1'b1) begin n_fail++; $display("FAIL mid_stray: got %b exp 1", stray_rdv); end
    do_reset();
  endtask

`ifdef DDR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    n = 0;
    m0_if.burstcount = 7'd2;
    m0_if.read = 1'b1;
    amm_if.ready = 1'b1;
    tick();
    tick();
    m0_if.read = 1'b0;
    amm_if.readdatavalid = 1'b1;
    settle();
    n_checks++; if (m0_if.readdatavalid !== 1'b1) begin n_fail++; $display("FAIL to_beat: got %b exp 1", m0_if.readdatavalid); end
    tick();
    amm_if.readdatavalid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      settle();
      if (rd_timeout) begin
        n = k;
        break;
      end
      tick();
    end
    n_checks++; if (n !== 17) begin n_fail++; $display("FAIL to_delay: got %0d exp 17", n); end
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL to_grant: got %b exp 00", grant); end
    tick();
    n_checks++; if (rd_timeout !== 1'b0) begin n_fail++; $display("FAIL to_pulse: got %b exp 0", rd_timeout); end
    amm_if.readdatavalid = 1'b1;
    tick();
    amm_if.readdatavalid = 1'b0;
    settle();
    n_checks++; if (stray_rdv !== 1'b1) begin n_fail++; $display("FAIL to_stray: got %b exp 1", stray_rdv); end
    m1_if.burstcount = 7'd1;
    m1_if.read = 1'b1;
    tick();
    settle();
    n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL to_next: got %b exp 10", grant); end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_read_single();
    test_write_burst();
    test_both_read();
    test_hold();
    test_stray();
    test_reset_mid();
`ifdef DDR_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
